// File: rtl/dest_pack_pkg.sv
// Shared widths and limits for the dest-domain byte packer and its FIFO.
package dest_pack_pkg;
    localparam int unsigned DATAWIDTH_DEF = 8;
    localparam int unsigned PACK_DEF      = 4;
    localparam int unsigned DEPTH_DEF     = 4;
    localparam int unsigned OUTW          = DATAWIDTH_DEF * PACK_DEF;
    localparam int unsigned CNTW          = $clog2(PACK_DEF + 1);
    localparam int unsigned PTRW          = $clog2(DEPTH_DEF);
    localparam logic [7:0]  DROP_MAX      = 8'hFF;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a pop frees the head slot for a same-edge push when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]                 wptr_q, rptr_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic                        do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mem_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q[PW-1:0]] <= wdata;
                wptr_q                <= wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end
endmodule

// File: rtl/dest_pack_buffer.sv
// Packs dest_data_valid beats into PACK-lane words and queues them on a valid/ready output.
module dest_pack_buffer
    import dest_pack_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
    parameter int unsigned PACK      = PACK_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF
) (
    input  logic                              dest_CLK,
    input  logic                              RST,
    input  logic [DATAWIDTH-1:0]              dest_data_in,
    input  logic                              dest_data_valid,
    input  logic                              flush,
    output logic [DATAWIDTH*PACK-1:0]         out_data,
    output logic [$clog2(PACK+1)-1:0]         out_count,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              overflow,
    output logic [7:0]                        drop_cnt,
    output logic                              busy
);
    localparam int unsigned OW = DATAWIDTH * PACK;
    localparam int unsigned CW = $clog2(PACK + 1);
    localparam int unsigned IW = $clog2(PACK);

    logic [PACK-1:0][DATAWIDTH-1:0] lanes_q, lanes_d, lanes_w;
    logic [IW-1:0]                  idx_q, idx_d;
    logic                           overflow_q, overflow_d;
    logic [7:0]                     drop_q, drop_d;
    logic [CW-1:0]                  n_fill;
    logic                           complete, push, drop;
    logic                           fifo_full, fifo_empty;
    logic [OW+CW-1:0]               fifo_rdata;

    // Lanes above idx are always zero (cleared on every push), so a flushed word is already padded.
    always_comb begin
        lanes_w = lanes_q;
        if (dest_data_valid) begin
            lanes_w[idx_q] = dest_data_in;
        end
        n_fill   = CW'(idx_q) + CW'(dest_data_valid);
        complete = dest_data_valid && (idx_q == IW'(PACK - 1));
        push     = complete || (flush && (n_fill != '0));
        drop     = push && fifo_full && !out_ready;

        lanes_d = lanes_w;
        idx_d   = idx_q;
        if (push) begin
            lanes_d = '0;
            idx_d   = '0;
        end else if (dest_data_valid) begin
            idx_d = idx_q + IW'(1);
        end

        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != DROP_MAX) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge dest_CLK or posedge RST) begin
        if (RST) begin
            lanes_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            lanes_q    <= lanes_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (OW + CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (dest_CLK),
        .rst   (RST),
        .push  (push),
        .wdata ({n_fill, lanes_w}),
        .pop   (out_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_data  = fifo_rdata[OW-1:0];
    assign out_count = fifo_rdata[OW +: CW];
    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;
    assign busy      = (idx_q != '0) || !fifo_empty;
endmodule

// File: tb/tb_dest_pack_buffer.sv
// Directed bench for dest_pack_buffer: packing, flush, overflow, full-with-pop and async reset.
module tb_dest_pack_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        dvalid, flush, ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        out_valid, overflow, busy;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dest_pack_buffer #(.DATAWIDTH(8), .PACK(4), .DEPTH(4)) dut (
        .dest_CLK        (clk),
        .RST             (rst),
        .dest_data_in    (din),
        .dest_data_valid (dvalid),
        .flush           (flush),
        .out_data        (out_data),
        .out_count       (out_count),
        .out_valid       (out_valid),
        .out_ready       (ready),
        .overflow        (overflow),
        .drop_cnt        (drop_cnt),
        .busy            (busy)
    );

    // One edge with the given strobes; returns 1 time unit after the edge with strobes cleared.
    task automatic step(input logic v, input logic [7:0] d, input logic f);
        dvalid = v; din = d; flush = f;
        @(posedge clk); #1;
        dvalid = 1'b0; flush = 1'b0; din = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; dvalid = 1'b0; flush = 1'b0; din = '0; ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; dvalid = 1'b0; flush = 1'b0; din = '0; ready = 1'b0;
        #2;
        n_cmp++; if ({out_valid, out_data, out_count, overflow, drop_cnt, busy} !== 45'd0) begin
            n_err++; $display("FAIL reset_outputs: got valid=%b data=%h cnt=%0d ovf=%b drop=%0d busy=%b, want all 0",
                              out_valid, out_data, out_count, overflow, drop_cnt, busy); end
        @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_pack();
        logic [7:0] b [8] = '{8'd2, 8'd20, 8'd22, 8'd11, 8'd3, 8'd6, 8'd7, 8'd8};
        ready = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, b[i], 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pack_early_valid: got %b want 0", out_valid); end
        step(1'b1, b[3], 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pack_w0_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 32'h0B161402) begin n_err++; $display("FAIL pack_w0_data: got %h want 0b161402", out_data); end
        n_cmp++; if (out_count !== 3'd4) begin n_err++; $display("FAIL pack_w0_count: got %0d want 4", out_count); end
        for (int i = 4; i < 7; i++) step(1'b1, b[i], 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pack_popped: got %b want 0", out_valid); end
        step(1'b1, b[7], 1'b0);
        n_cmp++; if (out_data !== 32'h08070603 || out_count !== 3'd4 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL pack_w1: got v=%b %h cnt=%0d want v=1 08070603 cnt=4", out_valid, out_data, out_count); end
        step(1'b0, 8'd0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL pack_drain: got valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_flush();
        ready = 1'b0;
        step(1'b1, 8'd13, 1'b0); step(1'b1, 8'd24, 1'b0); step(1'b1, 8'd35, 1'b0);
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL flush_partial: got valid=%b busy=%b want 0 1", out_valid, busy); end
        step(1'b0, 8'd0, 1'b1);
        n_cmp++; if (out_data !== 32'h0023180D || out_count !== 3'd3 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL flush_word: got v=%b %h cnt=%0d want v=1 0023180d cnt=3", out_valid, out_data, out_count); end
        ready = 1'b1; step(1'b0, 8'd0, 1'b0); ready = 1'b0;
        step(1'b0, 8'd0, 1'b1);
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL flush_empty_noop: got valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
        ready = 1'b0;
        for (int i = 0; i < 19; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
        n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++; $display("FAIL ovf_before: got ovf=%b drop=%0d want 0 0", overflow, drop_cnt); end
        step(1'b1, 8'h23, 1'b0);
        n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            n_err++; $display("FAIL ovf_flag: got ovf=%b drop=%0d want 1 1", overflow, drop_cnt); end
        n_cmp++; if (busy !== 1'b1 || dut.idx_q !== 2'd0) begin
            n_err++; $display("FAIL ovf_partial_cleared: got busy=%b idx=%0d want 1 0", busy, dut.idx_q); end
        step(1'b0, 8'd0, 1'b0); step(1'b0, 8'd0, 1'b0);
        n_cmp++; if (out_data !== exp[0] || out_valid !== 1'b1) begin
            n_err++; $display("FAIL ovf_hold: got v=%b %h want v=1 %h", out_valid, out_data, exp[0]); end
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_data !== exp[k] || out_count !== 3'd4 || out_valid !== 1'b1) begin
                n_err++; $display("FAIL ovf_drain_%0d: got v=%b %h cnt=%0d want v=1 %h cnt=4", k, out_valid, out_data, out_count, exp[k]); end
            step(1'b0, 8'd0, 1'b0);
        end
        n_cmp++; if (out_valid !== 1'b0 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            n_err++; $display("FAIL ovf_sticky: got valid=%b ovf=%b drop=%0d want 0 1 1", out_valid, overflow, drop_cnt); end
    endtask

    task automatic test_full_with_pop();
        logic [31:0] exp [4] = '{32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C, 32'h53525150};
        do_reset();
        for (int i = 0; i < 19; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
        ready = 1'b1;
        step(1'b1, 8'h53, 1'b0);
        ready = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++; $display("FAIL fullpop_no_ovf: got ovf=%b drop=%0d want 0 0", overflow, drop_cnt); end
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_data !== exp[k] || out_valid !== 1'b1) begin
                n_err++; $display("FAIL fullpop_drain_%0d: got v=%b %h want v=1 %h", k, out_valid, out_data, exp[k]); end
            step(1'b0, 8'd0, 1'b0);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_empty: got %b want 0", out_valid); end
        ready = 1'b0;
    endtask

    task automatic test_flush_same_edge();
        ready = 1'b0;
        step(1'b1, 8'd17, 1'b0);
        step(1'b1, 8'd18, 1'b1);
        n_cmp++; if (out_data !== 32'h00001211 || out_count !== 3'd2 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL flush_same_edge: got v=%b %h cnt=%0d want v=1 00001211 cnt=2", out_valid, out_data, out_count); end
        ready = 1'b1; step(1'b0, 8'd0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL flush_same_edge_once: got valid=%b busy=%b want 0 0", out_valid, busy); end
        ready = 1'b0;
    endtask

    task automatic test_async_reset();
        ready = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 8'h70 + 8'(i), 1'b0);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({out_valid, out_data, out_count, overflow, drop_cnt, busy} !== 45'd0) begin
            n_err++; $display("FAIL async_reset: got valid=%b data=%h cnt=%0d ovf=%b drop=%0d busy=%b want all 0",
                              out_valid, out_data, out_count, overflow, drop_cnt, busy); end
        #3 rst = 1'b0;
        step(1'b1, 8'd63, 1'b0); step(1'b1, 8'd32, 1'b0); step(1'b1, 8'd47, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale_idx: got valid=%b want 0", out_valid); end
        step(1'b1, 8'd36, 1'b0);
        n_cmp++; if (out_data !== 32'h242F203F || out_count !== 3'd4 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_new_word: got v=%b %h cnt=%0d want v=1 242f203f cnt=4", out_valid, out_data, out_count); end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_flush();
        test_overflow();
        test_full_with_pop();
        test_flush_same_edge();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
